// File: rtl/btb_update_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_arbiter_pkg
// Brief    : Shared types for the BTB update arbiter: branch-predictor state
//            encoding, queued update payload and arbiter FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package btb_update_arbiter_pkg;

    localparam int PC_W = 32;

    // 2-bit saturating predictor state as stored in the BTB
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } btb_state_t;

    // One pending BTB write
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
        btb_state_t      state;
    } btb_upd_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_FLUSH = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/btb_update_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_arbiter_if
// Brief    : Request, BTB-write and status signals of the BTB update arbiter.
//            master = requesters / BTB side, slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface btb_update_arbiter_if
    import btb_update_arbiter_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int DROP_W = 8
) ();

    // src A: ID-stage conditional branch resolutions
    logic              a_req;
    logic [PC_W-1:0]   a_pc;
    logic [PC_W-1:0]   a_target;
    logic              a_taken;
    logic [1:0]        a_state;
    logic              a_ready;
    // src B: EX-stage JAL/JALR resolutions (always taken)
    logic              b_req;
    logic [PC_W-1:0]   b_pc;
    logic [PC_W-1:0]   b_target;
    logic              b_ready;
    // flush control
    logic              flush_req;
    logic              flush_busy;
    // BTB write port
    logic              btb_upd_en;
    logic [PC_W-1:0]   btb_upd_pc;
    logic [PC_W-1:0]   btb_upd_target;
    logic              btb_upd_taken;
    logic [1:0]        btb_upd_state;
    logic              btb_inv_en;
    logic [IDX_W-1:0]  btb_inv_idx;
    // lost request counter
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output a_req, a_pc, a_target, a_taken, a_state,
        output b_req, b_pc, b_target,
        output flush_req,
        input  a_ready, b_ready, flush_busy,
        input  btb_upd_en, btb_upd_pc, btb_upd_target, btb_upd_taken, btb_upd_state,
        input  btb_inv_en, btb_inv_idx, drop_cnt
    );

    modport slave (
        input  a_req, a_pc, a_target, a_taken, a_state,
        input  b_req, b_pc, b_target,
        input  flush_req,
        output a_ready, b_ready, flush_busy,
        output btb_upd_en, btb_upd_pc, btb_upd_target, btb_upd_taken, btb_upd_state,
        output btb_inv_en, btb_inv_idx, drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/btb_update_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_arbiter_fifo
// Brief    : Small circular FIFO of pending BTB updates (one per source).
//            Clear has priority over push/pop. Pointers wrap mod QDEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_arbiter_fifo
    import btb_update_arbiter_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             push,
    input  wire btb_upd_t         push_data,
    input  wire logic             pop,
    output btb_upd_t              head,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    btb_upd_t         mem_q [QDEPTH];
    btb_upd_t         mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(QDEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointer/count/storage; QDEPTH is a power of two so increments wrap
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/btb_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_arbiter
// Brief    : Sequences the single BTB write port between ID-stage branch
//            resolutions (src A) and EX-stage jump resolutions (src B) with
//            round-robin grants, and walks all entries on a flush.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_arbiter
    import btb_update_arbiter_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int IDX_W       = 5,
    parameter int QDEPTH      = 2,
    parameter int DROP_W      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    btb_update_arbiter_if.slave bus
);

    localparam int               CNT_W    = $clog2(QDEPTH + 1);
    localparam int               ADD_W    = CNT_W + 2;
    localparam int               SUM_W    = DROP_W + ADD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rr_q, rr_d;          // 0 = A has priority, 1 = B
    logic              upd_en_q, upd_en_d;
    btb_upd_t          upd_q, upd_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    btb_upd_t          a_entry, b_entry, a_head, b_head;
    logic              a_full, a_empty, b_full, b_empty;
    logic [CNT_W-1:0]  a_count, b_count;
    logic              is_idle, flush_start;
    logic              a_ready, b_ready, a_push, b_push, a_drop, b_drop;
    logic              a_pop, b_pop;
    logic [ADD_W-1:0]  drop_add;
    logic [SUM_W-1:0]  drop_sum;

    assign a_entry = '{pc: bus.a_pc, target: bus.a_target, taken: bus.a_taken,
                       state: btb_state_t'(bus.a_state)};
    assign b_entry = '{pc: bus.b_pc, target: bus.b_target, taken: 1'b1,
                       state: STRONG_T};

    // Readiness reflects the current fill only; flush start beats any request
    assign is_idle     = (state_q == ARB_IDLE);
    assign flush_start = is_idle & bus.flush_req;
    assign a_ready     = is_idle & ~a_full;
    assign b_ready     = is_idle & ~b_full;
    assign a_push      = bus.a_req & a_ready & ~flush_start;
    assign b_push      = bus.b_req & b_ready & ~flush_start;
    assign a_drop      = bus.a_req & ~a_push;
    assign b_drop      = bus.b_req & ~b_push;

    // No pop on the flush-start cycle so no write can follow into the walk
    assign a_pop = is_idle & ~flush_start & ~a_empty & (b_empty | ~rr_q);
    assign b_pop = is_idle & ~flush_start & ~b_empty & (a_empty |  rr_q);

    btb_update_arbiter_fifo #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_start),
        .push      (a_push),
        .push_data (a_entry),
        .pop       (a_pop),
        .head      (a_head),
        .full      (a_full),
        .empty     (a_empty),
        .count     (a_count)
    );

    btb_update_arbiter_fifo #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_start),
        .push      (b_push),
        .push_data (b_entry),
        .pop       (b_pop),
        .head      (b_head),
        .full      (b_full),
        .empty     (b_empty),
        .count     (b_count)
    );

    // Flush FSM next state and invalidate index walk
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.flush_req) begin
                    state_d = ARB_FLUSH;
                    idx_d   = '0;
                end
            end
            ARB_FLUSH: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ARB_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Grant bookkeeping, registered write payload and saturating drop count
    always_comb begin
        rr_d     = rr_q;
        upd_en_d = a_pop | b_pop;
        upd_d    = upd_q;
        if (a_pop) begin
            upd_d = a_head;
            if (!b_empty) rr_d = 1'b1;
        end else if (b_pop) begin
            upd_d = b_head;
            if (!a_empty) rr_d = 1'b0;
        end
        drop_add = ADD_W'(a_drop) + ADD_W'(b_drop);
        if (flush_start) begin
            drop_add = drop_add + ADD_W'(a_count) + ADD_W'(b_count);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(drop_add);
        if (drop_sum[SUM_W-1:DROP_W] != '0) begin
            drop_d = DROP_MAX;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            idx_q    <= '0;
            rr_q     <= 1'b0;
            upd_en_q <= 1'b0;
            upd_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            upd_en_q <= upd_en_d;
            upd_q    <= upd_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.a_ready        = a_ready;
    assign bus.b_ready        = b_ready;
    assign bus.flush_busy     = (state_q == ARB_FLUSH);
    assign bus.btb_inv_en     = (state_q == ARB_FLUSH);
    assign bus.btb_inv_idx    = idx_q;
    assign bus.btb_upd_en     = upd_en_q;
    assign bus.btb_upd_pc     = upd_q.pc;
    assign bus.btb_upd_target = upd_q.target;
    assign bus.btb_upd_taken  = upd_q.taken;
    assign bus.btb_upd_state  = upd_q.state;
    assign bus.drop_cnt       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_update_arbiter
// Brief    : Directed bench for btb_update_arbiter with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_update_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btb_update_arbiter_if #(.IDX_W(5), .DROP_W(8)) bus ();

    btb_update_arbiter #(
        .NUM_ENTRIES (32),
        .IDX_W       (5),
        .QDEPTH      (2),
        .DROP_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          exp_drop = 0;
    logic [66:0] exp_q [$];
    logic [66:0] mon_act;
    logic [66:0] mon_exp;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_req = 1'b0; bus.a_pc = '0; bus.a_target = '0; bus.a_taken = 1'b0; bus.a_state = '0;
        bus.b_req = 1'b0; bus.b_pc = '0; bus.b_target = '0;
        bus.flush_req = 1'b0;
    endtask

    task automatic drive_a(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic [1:0] st);
        bus.a_req = 1'b1; bus.a_pc = pc; bus.a_target = tgt; bus.a_taken = tk; bus.a_state = st;
    endtask

    task automatic drive_b(input logic [31:0] pc, input logic [31:0] tgt);
        bus.b_req = 1'b1; bus.b_pc = pc; bus.b_target = tgt;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain", 67'(exp_q.size()), 67'd0);
    endtask

    // Monitor: every BTB write strobe is matched against the next expected write
    always @(negedge clk) begin
        if (rst && bus.btb_upd_en) begin
            mon_act = {bus.btb_upd_pc, bus.btb_upd_target, bus.btb_upd_taken, bus.btb_upd_state};
            check("upd_inv_exclusive", 67'(bus.btb_inv_en), 67'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_upd", mon_act, 67'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("upd_payload", mon_act, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a_rdy_exp;
        logic [3:0] b_rdy_exp;
        a_rdy_exp = 4'b0111;
        b_rdy_exp = 4'b1011;
        clear_inputs();

        // Reset values
        rst = 1'b0;
        repeat (3) tick();
        check("rst_upd_en",  67'(bus.btb_upd_en), 67'd0);
        check("rst_inv_en",  67'(bus.btb_inv_en), 67'd0);
        check("rst_busy",    67'(bus.flush_busy), 67'd0);
        check("rst_a_ready", 67'(bus.a_ready), 67'd1);
        check("rst_b_ready", 67'(bus.b_ready), 67'd1);
        check("rst_drop",    67'(bus.drop_cnt), 67'd0);
        check("rst_payload", {bus.btb_upd_pc, bus.btb_upd_target, bus.btb_upd_taken, bus.btb_upd_state}, 67'd0);
        rst = 1'b1;
        tick();

        // Single src A update, one-cycle latency, single strobe
        drive_a(32'h100, 32'h200, 1'b1, 2'b01);
        exp_q.push_back({32'h100, 32'h200, 1'b1, 2'b01});
        tick();
        clear_inputs();
        check("t1_lat0", 67'(bus.btb_upd_en), 67'd0);
        tick();
        check("t1_lat1", 67'(bus.btb_upd_en), 67'd1);
        tick();
        check("t1_single", 67'(bus.btb_upd_en), 67'd0);
        wait_drain();

        // src B update is forced taken / STRONG_T
        drive_b(32'h40, 32'h80);
        exp_q.push_back({32'h40, 32'h80, 1'b1, 2'b11});
        tick();
        clear_inputs();
        wait_drain();

        // Contention: alternating grants, FIFOs fill, two requests dropped
        exp_q.push_back({32'h1001, 32'h2001, 1'b1, 2'b01});
        exp_q.push_back({32'h3001, 32'h4001, 1'b1, 2'b11});
        exp_q.push_back({32'h1002, 32'h2002, 1'b0, 2'b10});
        exp_q.push_back({32'h3002, 32'h4002, 1'b1, 2'b11});
        exp_q.push_back({32'h1003, 32'h2003, 1'b1, 2'b11});
        exp_q.push_back({32'h3004, 32'h4004, 1'b1, 2'b11});
        for (int k = 1; k <= 4; k++) begin
            drive_a(32'h1000 + 32'(k), 32'h2000 + 32'(k), k[0], k[1:0]);
            drive_b(32'h3000 + 32'(k), 32'h4000 + 32'(k));
            check($sformatf("t2_a_ready_%0d", k), 67'(bus.a_ready), 67'(a_rdy_exp[k-1]));
            check($sformatf("t2_b_ready_%0d", k), 67'(bus.b_ready), 67'(b_rdy_exp[k-1]));
            tick();
        end
        clear_inputs();
        exp_drop += 2;
        wait_drain();
        check("t2_drop", 67'(bus.drop_cnt), 67'(exp_drop));

        // Flush with two queued entries, plus a re-request mid-walk
        drive_a(32'h500, 32'h501, 1'b0, 2'b00);
        drive_b(32'h600, 32'h601);
        tick();
        clear_inputs();
        bus.flush_req = 1'b1;
        tick();
        clear_inputs();
        exp_drop += 2;
        check("t4_drop_discard", 67'(bus.drop_cnt), 67'(exp_drop));
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t4_inv_en_%0d", i), 67'(bus.btb_inv_en), 67'd1);
            check($sformatf("t4_inv_idx_%0d", i), 67'(bus.btb_inv_idx), 67'(i));
            check($sformatf("t4_upd_en_%0d", i), 67'(bus.btb_upd_en), 67'd0);
            if (i == 5) begin
                check("t5_a_ready", 67'(bus.a_ready), 67'd0);
                bus.flush_req = 1'b1;
                drive_a(32'h900, 32'h901, 1'b1, 2'b10);
                exp_drop += 1;
            end
            tick();
            clear_inputs();
        end
        check("t4_busy_done", 67'(bus.flush_busy), 67'd0);
        check("t4_inv_done",  67'(bus.btb_inv_en), 67'd0);
        check("t5_drop",      67'(bus.drop_cnt), 67'(exp_drop));

        // Reset in the middle of a flush walk
        bus.flush_req = 1'b1;
        tick();
        clear_inputs();
        repeat (10) tick();
        check("t6_idx10", 67'(bus.btb_inv_idx), 67'd10);
        rst = 1'b0;
        tick();
        exp_drop = 0;
        check("t6_busy",    67'(bus.flush_busy), 67'd0);
        check("t6_inv_en",  67'(bus.btb_inv_en), 67'd0);
        check("t6_inv_idx", 67'(bus.btb_inv_idx), 67'd0);
        check("t6_a_ready", 67'(bus.a_ready), 67'd1);
        check("t6_b_ready", 67'(bus.b_ready), 67'd1);
        check("t6_drop",    67'(bus.drop_cnt), 67'd0);
        rst = 1'b1;
        tick();
        drive_a(32'h700, 32'h704, 1'b0, 2'b10);
        exp_q.push_back({32'h700, 32'h704, 1'b0, 2'b10});
        tick();
        clear_inputs();
        wait_drain();

        // Drop counter saturation: every cycle loses both requests
        bus.flush_req = 1'b1;
        drive_a(32'hA00, 32'hA04, 1'b1, 2'b11);
        drive_b(32'hB00, 32'hB04);
        for (int i = 0; i < 150; i++) begin
            tick();
            exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
            if (i == 9) check("sat_mid", 67'(bus.drop_cnt), 67'(exp_drop));
        end
        clear_inputs();
        check("sat_full", 67'(bus.drop_cnt), 67'd255);
        for (int i = 0; i < 40 && bus.flush_busy; i++) tick();
        check("sat_idle", 67'(bus.flush_busy), 67'd0);
        check("sat_hold", 67'(bus.drop_cnt), 67'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
